// File: rtl/alu_rs_sched_pkg.sv
// ============================================================================
// Module : alu_rs_sched_pkg
// Brief  : Shared order codes, default widths and operand-tag layout for the
//          ALU reservation station (optional feature macro: ALU_RS_FASTWAKE_EN)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_rs_sched_pkg;

    localparam int c_rs_size = 8;
    localparam int c_tag_w   = 4;
    localparam int c_order_w = 6;

    // Operand tag is {pending, tag}; the pending flag sits directly above the tag.
    localparam int c_opnd_pend_bit = c_tag_w;
    localparam int c_opnd_w        = c_tag_w + 1;

    typedef enum logic [c_order_w-1:0] {
        ORD_NOP   = 6'd0,
        ORD_LUI, ORD_AUIPC, ORD_JAL, ORD_JALR,
        ORD_BEQ, ORD_BNE, ORD_BLT, ORD_BGE, ORD_BLTU, ORD_BGEU,
        ORD_ADDI, ORD_SLTI, ORD_SLTIU, ORD_XORI, ORD_ORI, ORD_ANDI,
        ORD_SLLI, ORD_SRLI, ORD_SRAI,
        ORD_ADD, ORD_SUB, ORD_SLL, ORD_SLT, ORD_SLTU,
        ORD_XOR, ORD_SRL, ORD_SRA, ORD_OR, ORD_AND
    } order_e;

endpackage

`default_nettype wire

// File: rtl/alu_rs_sched_rr_pick.sv
// ============================================================================
// Module : alu_rs_sched_rr_pick
// Brief  : Round-robin picker: first requester at or after i_ptr, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rs_sched_rr_pick
    import alu_rs_sched_pkg::*;
#(
    parameter int N     = c_rs_size,
    parameter int IDX_W = $clog2(c_rs_size)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_any
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // N is a power of two, so the index addition wraps for free.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = i_ptr + k[IDX_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs_sched.sv
// ============================================================================
// Module : alu_rs_sched
// Brief  : ALU reservation station with CDB wakeup and round-robin issue.
//          Optional macro ALU_RS_FASTWAKE_EN: issue in the CDB wakeup cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rs_sched
    import alu_rs_sched_pkg::*;
#(
    parameter int RS_SIZE = c_rs_size,
    parameter int TAG_W   = c_tag_w,
    parameter int ORDER_W = c_order_w
) (
    input  logic               clk_in,
    input  logic               rstn_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [ORDER_W-1:0] disp_order,
    input  logic [31:0]        disp_vj,
    input  logic [31:0]        disp_vk,
    input  logic [TAG_W:0]     disp_qj,
    input  logic [TAG_W:0]     disp_qk,
    input  logic [31:0]        disp_a,
    input  logic [31:0]        disp_pc,
    input  logic [TAG_W-1:0]   disp_tag,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [31:0]        cdb_value,
    output logic [ORDER_W-1:0] ex_order,
    output logic [31:0]        ex_vj,
    output logic [31:0]        ex_vk,
    output logic [31:0]        ex_a,
    output logic [31:0]        ex_pc,
    input  logic [31:0]        ex_value,
    input  logic [31:0]        ex_topc,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [TAG_W-1:0]   res_tag,
    output logic [31:0]        res_value,
    output logic [31:0]        res_topc
);

    localparam int c_idx_w = $clog2(RS_SIZE);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(RS_SIZE);

    logic [RS_SIZE-1:0] r_valid;
    logic [RS_SIZE-1:0] r_qj_p;
    logic [RS_SIZE-1:0] r_qk_p;
    logic [TAG_W-1:0]   r_qj_t  [RS_SIZE];
    logic [TAG_W-1:0]   r_qk_t  [RS_SIZE];
    logic [ORDER_W-1:0] r_order [RS_SIZE];
    logic [31:0]        r_vj    [RS_SIZE];
    logic [31:0]        r_vk    [RS_SIZE];
    logic [31:0]        r_a     [RS_SIZE];
    logic [31:0]        r_pc    [RS_SIZE];
    logic [TAG_W-1:0]   r_tag   [RS_SIZE];

    logic [c_idx_w-1:0] r_rr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_res_valid;
    logic [TAG_W-1:0]   r_res_tag;
    logic [31:0]        r_res_value;
    logic [31:0]        r_res_topc;

    logic [RS_SIZE-1:0] w_wake_j;
    logic [RS_SIZE-1:0] w_wake_k;
    logic [RS_SIZE-1:0] w_req;
    logic [RS_SIZE-1:0] w_grant;
    logic               w_any;
    logic               w_issue;
    logic               w_disp;
    logic [c_idx_w-1:0] w_sel;
    logic [c_idx_w-1:0] w_free;
    logic               w_dqj_hit;
    logic               w_dqk_hit;

    for (genvar i = 0; i < RS_SIZE; i++) begin : g_entry
        assign w_wake_j[i] = cdb_valid && r_qj_p[i] && (r_qj_t[i] == cdb_tag);
        assign w_wake_k[i] = cdb_valid && r_qk_p[i] && (r_qk_t[i] == cdb_tag);
`ifdef ALU_RS_FASTWAKE_EN
        assign w_req[i] = r_valid[i] && (!r_qj_p[i] || w_wake_j[i])
                                     && (!r_qk_p[i] || w_wake_k[i]);
`else
        assign w_req[i] = r_valid[i] && !r_qj_p[i] && !r_qk_p[i];
`endif
    end

    alu_rs_sched_rr_pick #(
        .N     (RS_SIZE),
        .IDX_W (c_idx_w)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_issue    = w_any && (!r_res_valid || res_ready);
    assign disp_ready = (r_count < c_full);
    assign w_disp     = disp_valid && disp_ready;
    assign w_dqj_hit  = cdb_valid && disp_qj[TAG_W] && (disp_qj[TAG_W-1:0] == cdb_tag);
    assign w_dqk_hit  = cdb_valid && disp_qk[TAG_W] && (disp_qk[TAG_W-1:0] == cdb_tag);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (w_grant[i]) w_sel = i[c_idx_w-1:0];
        end
    end

    // Lowest free index: scan downward so the last hit is the smallest one.
    always_comb begin
        w_free = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free = i[c_idx_w-1:0];
        end
    end

    always_comb begin
        ex_order = '0;
        ex_vj    = '0;
        ex_vk    = '0;
        ex_a     = '0;
        ex_pc    = '0;
        if (w_issue) begin
            ex_order = r_order[w_sel];
            ex_vj    = r_vj[w_sel];
            ex_vk    = r_vk[w_sel];
            ex_a     = r_a[w_sel];
            ex_pc    = r_pc[w_sel];
`ifdef ALU_RS_FASTWAKE_EN
            if (r_qj_p[w_sel]) ex_vj = cdb_value;
            if (r_qk_p[w_sel]) ex_vk = cdb_value;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            r_valid     <= '0;
            r_qj_p      <= '0;
            r_qk_p      <= '0;
            r_rr_ptr    <= '0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_value <= '0;
            r_res_topc  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_valid     <= '0;
                r_count     <= '0;
                r_res_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (w_wake_j[i]) begin
                        r_qj_p[i] <= 1'b0;
                        r_vj[i]   <= cdb_value;
                    end
                    if (w_wake_k[i]) begin
                        r_qk_p[i] <= 1'b0;
                        r_vk[i]   <= cdb_value;
                    end
                end

                if (w_issue) begin
                    r_valid[w_sel] <= 1'b0;
                    r_res_valid    <= 1'b1;
                    r_res_tag      <= r_tag[w_sel];
                    r_res_value    <= ex_value;
                    r_res_topc     <= ex_topc;
                    r_rr_ptr       <= w_sel + 1'b1;
                end else if (res_ready) begin
                    r_res_valid <= 1'b0;
                end

                // The free slot is never the issuing slot, so these writes never collide.
                if (w_disp) begin
                    r_valid[w_free] <= 1'b1;
                    r_order[w_free] <= disp_order;
                    r_qj_p[w_free]  <= disp_qj[TAG_W] && !w_dqj_hit;
                    r_qj_t[w_free]  <= disp_qj[TAG_W-1:0];
                    r_vj[w_free]    <= w_dqj_hit ? cdb_value : disp_vj;
                    r_qk_p[w_free]  <= disp_qk[TAG_W] && !w_dqk_hit;
                    r_qk_t[w_free]  <= disp_qk[TAG_W-1:0];
                    r_vk[w_free]    <= w_dqk_hit ? cdb_value : disp_vk;
                    r_a[w_free]     <= disp_a;
                    r_pc[w_free]    <= disp_pc;
                    r_tag[w_free]   <= disp_tag;
                end

                r_count <= r_count + c_cnt_w'(w_disp) - c_cnt_w'(w_issue);
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_tag   = r_res_tag;
    assign res_value = r_res_value;
    assign res_topc  = r_res_topc;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs_sched.sv
// ============================================================================
// Module : tb_alu_rs_sched
// Brief  : Directed bench for alu_rs_sched with a small behavioural EX model.
//          Honours ALU_RS_FASTWAKE_EN for wakeup latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_rs_sched;
    import alu_rs_sched_pkg::*;

`ifdef ALU_RS_FASTWAKE_EN
    localparam int c_wake_lat = 0;
`else
    localparam int c_wake_lat = 1;
`endif

    logic        clk;
    logic        rstn_in, rdy_in, flush_in;
    logic        disp_valid, disp_ready;
    logic [5:0]  disp_order;
    logic [31:0] disp_vj, disp_vk, disp_a, disp_pc;
    logic [4:0]  disp_qj, disp_qk;
    logic [3:0]  disp_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [5:0]  ex_order;
    logic [31:0] ex_vj, ex_vk, ex_a, ex_pc, ex_value, ex_topc;
    logic        res_valid, res_ready;
    logic [3:0]  res_tag;
    logic [31:0] res_value, res_topc;

    int checks   = 0;
    int failures = 0;

    alu_rs_sched u_dut (
        .clk_in     (clk),
        .rstn_in    (rstn_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_order (disp_order),
        .disp_vj    (disp_vj),
        .disp_vk    (disp_vk),
        .disp_qj    (disp_qj),
        .disp_qk    (disp_qk),
        .disp_a     (disp_a),
        .disp_pc    (disp_pc),
        .disp_tag   (disp_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .ex_order   (ex_order),
        .ex_vj      (ex_vj),
        .ex_vk      (ex_vk),
        .ex_a       (ex_a),
        .ex_pc      (ex_pc),
        .ex_value   (ex_value),
        .ex_topc    (ex_topc),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_tag    (res_tag),
        .res_value  (res_value),
        .res_topc   (res_topc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ex_value = 32'd0;
        case (ex_order)
            ORD_ADD:  ex_value = ex_vj + ex_vk;
            ORD_ADDI: ex_value = ex_vj + ex_a;
            default:  ex_value = 32'd0;
        endcase
        ex_topc = ex_pc + 32'd4;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic dispatch(input logic [5:0] ord, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [31:0] a, input logic [31:0] pc,
                            input logic [4:0] qj, input logic [4:0] qk, input logic [3:0] tag);
        disp_valid = 1'b1;
        disp_order = ord;
        disp_vj    = vj;
        disp_vk    = vk;
        disp_a     = a;
        disp_pc    = pc;
        disp_qj    = qj;
        disp_qk    = qk;
        disp_tag   = tag;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_value = v;
        step();
        cdb_valid = 1'b0;
    endtask

    initial begin
        rstn_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        disp_valid = 1'b0; disp_order = '0; disp_vj = '0; disp_vk = '0;
        disp_a = '0; disp_pc = '0; disp_qj = '0; disp_qk = '0; disp_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; res_ready = 1'b1;

        // Reset held for two edges
        step();
        step();
        rstn_in = 1'b1;
        chk("rst_res_valid",  32'(res_valid),  32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_ex_order",   32'(ex_order),   32'd0);
        chk("rst_res_value",  res_value,       32'd0);

        // ADDI with ready operands: result two edges after dispatch
        dispatch(ORD_ADDI, 32'd5, 32'd0, 32'd3, 32'h100, 5'h00, 5'h00, 4'd2);
        chk("addi_lat1_valid", 32'(res_valid), 32'd0);
        step();
        chk("addi_valid", 32'(res_valid), 32'd1);
        chk("addi_tag",   32'(res_tag),   32'd2);
        chk("addi_value", res_value,      32'd8);
        chk("addi_topc",  res_topc,       32'h104);
        step();
        chk("addi_drain", 32'(res_valid), 32'd0);

        // ADD waiting on tag 7, woken by the CDB
        dispatch(ORD_ADD, 32'd0, 32'd10, 32'd0, 32'h200, 5'h17, 5'h00, 4'd3);
        repeat (3) step();
        chk("wake_pending_valid", 32'(res_valid), 32'd0);
        chk("wake_pending_ex",    32'(ex_order),  32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'd4;
`ifdef ALU_RS_FASTWAKE_EN
        #1;
        chk("fast_ex_order", 32'(ex_order), 32'(ORD_ADD));
        chk("fast_ex_vj",    ex_vj,         32'd4);
`endif
        step();
        cdb_valid = 1'b0;
`ifndef ALU_RS_FASTWAKE_EN
        chk("wake_slow_gap", 32'(res_valid), 32'd0);
        step();
`endif
        chk("wake_valid", 32'(res_valid), 32'd1);
        chk("wake_tag",   32'(res_tag),   32'd3);
        chk("wake_value", res_value,      32'd14);
        step();

        // Round robin: slots 0 and 3 wake together with rr_ptr = 1
        dispatch(ORD_ADDI, 32'd0, 32'd0, 32'd100, 32'h0, 5'h15, 5'h00, 4'd10);
        dispatch(ORD_ADDI, 32'd0, 32'd0, 32'd1,   32'h0, 5'h16, 5'h00, 4'd11);
        dispatch(ORD_ADDI, 32'd0, 32'd0, 32'd1,   32'h0, 5'h16, 5'h00, 4'd12);
        dispatch(ORD_ADDI, 32'd0, 32'd0, 32'd300, 32'h0, 5'h15, 5'h00, 4'd13);
        chk("rr_idle", 32'(res_valid), 32'd0);
        cdb(4'd5, 32'd1);
        repeat (c_wake_lat) step();
        chk("rr_first_tag",    32'(res_tag), 32'd13);
        chk("rr_first_value",  res_value,    32'd301);
        step();
        chk("rr_second_tag",   32'(res_tag), 32'd10);
        chk("rr_second_value", res_value,    32'd101);
        step();
        cdb(4'd6, 32'd2);
        repeat (3) step();
        chk("rr_drain_valid", 32'(res_valid),  32'd0);
        chk("rr_drain_ready", 32'(disp_ready), 32'd1);

        // Fill all eight slots with pending operands
        for (int i = 0; i < 8; i++) begin
            dispatch(ORD_ADD, 32'd0, 32'(i), 32'd0, 32'h0, {1'b1, 4'(i)}, 5'h00, 4'(8 + i));
        end
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_no_result",  32'(res_valid),  32'd0);

        // Backpressure: first result holds, second ready entry waits
        res_ready = 1'b0;
        cdb(4'd2, 32'h20);
        repeat (c_wake_lat) step();
        chk("bp_valid",      32'(res_valid),  32'd1);
        chk("bp_tag",        32'(res_tag),    32'd10);
        chk("bp_value",      res_value,       32'h22);
        chk("bp_disp_ready", 32'(disp_ready), 32'd1);
        cdb(4'd5, 32'h50);
        step();
        step();
        chk("bp_hold_tag",   32'(res_tag),  32'd10);
        chk("bp_hold_value", res_value,     32'h22);
        chk("bp_blocked_ex", 32'(ex_order), 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp_next_valid", 32'(res_valid), 32'd1);
        chk("bp_next_tag",   32'(res_tag),   32'd13);
        chk("bp_next_value", res_value,      32'h55);

        // Flush with entries held and a result pending; same-cycle dispatch dropped
        flush_in = 1'b1;
        dispatch(ORD_ADDI, 32'd1, 32'd0, 32'd1, 32'h0, 5'h00, 5'h00, 4'd4);
        flush_in = 1'b0;
        chk("flush_res_valid",  32'(res_valid),  32'd0);
        chk("flush_disp_ready", 32'(disp_ready), 32'd1);
        chk("flush_ex_order",   32'(ex_order),   32'd0);
        res_ready = 1'b1;
        cdb(4'd0, 32'd0);
        cdb(4'd1, 32'd0);
        step();
        step();
        chk("flush_no_stale", 32'(res_valid), 32'd0);

        // rdy_in low freezes state: the dispatch is not captured
        rdy_in = 1'b0;
        dispatch(ORD_ADDI, 32'd7, 32'd0, 32'd1, 32'h0, 5'h00, 5'h00, 4'd6);
        step();
        chk("freeze_res_valid", 32'(res_valid), 32'd0);
        rdy_in = 1'b1;
        step();
        step();
        chk("freeze_no_entry", 32'(res_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
